// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue-side controller for the Alu datapath.
// Ports: clk, clear_n (async low reset); instr_valid/instr_ready with
//   opcode, ra_data, rb_data in; one-hot op strobes plus A/B out to the
//   Alu; C (64-bit) back; result_valid/result_ready with z_hi, z_lo, err.
module alu_op_sequencer #(
  parameter int SIMPLE_LAT = 1,
  parameter int MUL_LAT    = 3,
  parameter int DIV_LAT    = 34
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [4:0]  opcode,
  input  logic [31:0] ra_data,
  input  logic [31:0] rb_data,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        IncPC,
  output logic [31:0] A,
  output logic [31:0] B,
  input  logic [63:0] C,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] z_hi,
  output logic [31:0] z_lo,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [4:0] OP_MUL  = 5'd4;
  localparam logic [4:0] OP_DIV  = 5'd5;
  localparam logic [4:0] OP_LAST = 5'd12;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] z_hi_q, z_hi_d;
  logic [31:0] z_lo_q, z_lo_d;
  logic        err_q, err_d;
  logic [12:0] stb_q, stb_d;
  logic [5:0]  lat;
  logic        legal;

  assign legal = (opcode <= OP_LAST);

  always_comb begin
    lat = 6'(SIMPLE_LAT);
    unique case (1'b1)
      (opcode == OP_MUL): lat = 6'(MUL_LAT);
      (opcode == OP_DIV): lat = 6'(DIV_LAT);
      default:            lat = 6'(SIMPLE_LAT);
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    z_hi_d  = z_hi_q;
    z_lo_d  = z_lo_q;
    err_d   = err_q;
    stb_d   = stb_q;
    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          a_d = ra_data;
          b_d = rb_data;
          if (legal) begin
            cnt_d   = lat;
            stb_d   = 13'(1) << opcode;
            state_d = EXEC;
          end else begin
            // Illegal ops skip the Alu entirely.
            err_d   = 1'b1;
            z_hi_d  = '0;
            z_lo_d  = '0;
            state_d = RESP;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 6'd1;
        // Capture on the last strobe cycle; the strobe drops with it.
        if (cnt_q == 6'd1) begin
          z_hi_d  = C[63:32];
          z_lo_d  = C[31:0];
          err_d   = 1'b0;
          stb_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      z_hi_q  <= '0;
      z_lo_q  <= '0;
      err_q   <= 1'b0;
      stb_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      z_hi_q  <= z_hi_d;
      z_lo_q  <= z_lo_d;
      err_q   <= err_d;
      stb_q   <= stb_d;
    end
  end

  assign instr_ready  = (state_q == IDLE) && clear_n;
  assign result_valid = (state_q == RESP);
  assign A            = a_q;
  assign B            = b_q;
  assign z_hi         = z_hi_q;
  assign z_lo         = z_lo_q;
  assign err          = err_q;

  assign AND   = stb_q[0];
  assign OR    = stb_q[1];
  assign ADD   = stb_q[2];
  assign SUB   = stb_q[3];
  assign MUL   = stb_q[4];
  assign DIV   = stb_q[5];
  assign SHR   = stb_q[6];
  assign SHL   = stb_q[7];
  assign ROR   = stb_q[8];
  assign ROL   = stb_q[9];
  assign NEG   = stb_q[10];
  assign NOT   = stb_q[11];
  assign IncPC = stb_q[12];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: table vectors plus hand sequences, with a latency
// aware Alu model and a result scoreboard.
module tb_alu_op_sequencer;

  localparam int SL = 1;
  localparam int ML = 3;
  localparam int DL = 34;

  logic        clk = 1'b0;
  logic        clear_n = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [4:0]  opcode = '0;
  logic [31:0] ra_data = '0;
  logic [31:0] rb_data = '0;
  logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHL;
  logic        ROR, ROL, NEG, NOT, IncPC;
  logic [31:0] A, B;
  logic [63:0] C;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [31:0] z_hi, z_lo;
  logic        err;
  logic [12:0] stb;

  alu_op_sequencer #(
    .SIMPLE_LAT(SL),
    .MUL_LAT(ML),
    .DIV_LAT(DL)
  ) dut (
    .clk(clk), .clear_n(clear_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .ra_data(ra_data), .rb_data(rb_data),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL),
    .DIV(DIV), .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL),
    .NEG(NEG), .NOT(NOT), .IncPC(IncPC),
    .A(A), .B(B), .C(C),
    .result_valid(result_valid), .result_ready(result_ready),
    .z_hi(z_hi), .z_lo(z_lo), .err(err)
  );

  always #5 clk = ~clk;

  assign stb = {IncPC, NOT, NEG, ROL, ROR, SHL, SHR,
                DIV, MUL, SUB, ADD, OR, AND};

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s bound expired", nm);
  endtask

  // Alu model: C is only correct once the strobe has been up for LAT cycles.
  function automatic int lat_of(input int idx);
    if (idx == 4) return ML;
    if (idx == 5) return DL;
    return SL;
  endfunction

  function automatic logic [63:0] alu_f(input int idx,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] aa;
    logic [63:0] r;
    aa = {a, a};
    r = '0;
    case (idx)
      0: r = {32'd0, a & b};
      1: r = {32'd0, a | b};
      2: r = {32'd0, a + b};
      3: r = {32'd0, a - b};
      4: r = {32'd0, a} * {32'd0, b};
      5: r = {a % b, a / b};
      6: r = {32'd0, a >> b[4:0]};
      7: r = {32'd0, a << b[4:0]};
      8: begin aa = aa >> b[4:0]; r = {32'd0, aa[31:0]}; end
      9: begin aa = aa << b[4:0]; r = {32'd0, aa[63:32]}; end
      10: r = {32'd0, -a};
      11: r = {32'd0, ~a};
      12: r = {32'd0, a + 32'd1};
      default: r = '0;
    endcase
    return r;
  endfunction

  int run = 0;
  always @(posedge clk) begin
    if (stb == '0) run <= 0;
    else run <= run + 1;
  end

  int c_idx;
  always_comb begin
    c_idx = 0;
    C = 64'hDEAD_BEEF_0BAD_F00D;
    for (int i = 0; i < 13; i++) if (stb[i]) c_idx = i;
    if (stb != '0 && run + 1 >= lat_of(c_idx))
      C = alu_f(c_idx, A, B);
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int on_cnt = 0;
  int off_cnt = 0;
  bit seen = 0;
  int idle_bad = 0;
  logic [12:0] mask;

  always @(negedge clk) begin
    if (!clear_n) begin
      sb.delete();
      on_cnt = 0;
      off_cnt = 0;
      seen = 0;
    end else if (sb.size() == 0) begin
      if (stb != '0 || result_valid) idle_bad++;
    end else begin
      mask = (sb[0].op <= 5'd12) ? (13'd1 << sb[0].op) : 13'd0;
      on_cnt += $countones(stb & mask);
      off_cnt += $countones(stb & ~mask);
      if (result_valid && !seen) begin
        seen = 1;
        chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
      end
      if (result_valid && result_ready) begin
        chk("z_hi", {32'd0, z_hi}, {32'd0, sb[0].hi});
        chk("z_lo", {32'd0, z_lo}, {32'd0, sb[0].lo});
        chk("err", {63'd0, err}, {63'd0, sb[0].err});
        chk("strobe_cycles", 64'(on_cnt), 64'(sb[0].lat));
        chk("other_strobes", 64'(off_cnt), 64'd0);
        void'(sb.pop_front());
        on_cnt = 0;
        off_cnt = 0;
        seen = 0;
      end
    end
  end

  task automatic push(input vec_t v);
    sb.push_back('{v.op, v.hi, v.lo, v.err, v.lat, cyc});
  endtask

  task automatic issue(input vec_t v);
    int n;
    @(posedge clk);
    #1;
    instr_valid = 1'b1;
    opcode = v.op;
    ra_data = v.ra;
    rb_data = v.rb;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (instr_ready) break;
    end
    if (n == 100) begin
      fail("issue_timeout");
      instr_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      push(v);
      instr_valid = 1'b0;
      // Operand churn outside IDLE must be ignored.
      ra_data = $urandom;
      rb_data = $urandom;
    end
  endtask

  task automatic drain(input int lat);
    int busy;
    busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (instr_ready) break;
      busy++;
    end
    chk("busy_cycles", 64'(busy), 64'(lat + 1));
    chk("drained", 64'(sb.size()), 64'd0);
  endtask

  vec_t vt[17];
  vec_t v;
  int bad;

  initial begin
    vt[0]  = '{5'd2,  32'd22, 32'd24, 32'd0, 32'd46, 1'b0, SL};
    vt[1]  = '{5'd4,  32'd22, 32'd24, 32'd0, 32'd528, 1'b0, ML};
    vt[2]  = '{5'd5,  32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DL};
    vt[3]  = '{5'd20, 32'd5, 32'd6, 32'd0, 32'd0, 1'b1, 0};
    vt[4]  = '{5'd11, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, SL};
    vt[5]  = '{5'd0,  32'hF0F0_1234, 32'h0FF0_FF00, 32'd0,
               32'h00F0_1200, 1'b0, SL};
    vt[6]  = '{5'd1,  32'hF000_0000, 32'h0000_000F, 32'd0,
               32'hF000_000F, 1'b0, SL};
    vt[7]  = '{5'd6,  32'h8000_0000, 32'd4, 32'd0,
               32'h0800_0000, 1'b0, SL};
    vt[8]  = '{5'd7,  32'd1, 32'd31, 32'd0, 32'h8000_0000, 1'b0, SL};
    vt[9]  = '{5'd8,  32'd1, 32'd1, 32'd0, 32'h8000_0000, 1'b0, SL};
    vt[10] = '{5'd9,  32'h8000_0001, 32'd4, 32'd0, 32'h18, 1'b0, SL};
    vt[11] = '{5'd10, 32'd5, 32'd0, 32'd0, 32'hFFFF_FFFB, 1'b0, SL};
    vt[12] = '{5'd12, 32'h100, 32'd0, 32'd0, 32'h101, 1'b0, SL};
    vt[13] = '{5'd13, 32'd1, 32'd1, 32'd0, 32'd0, 1'b1, 0};
    vt[14] = '{5'd4,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
               32'h0000_0001, 1'b0, ML};
    vt[15] = '{5'd31, 32'd7, 32'd7, 32'd0, 32'd0, 1'b1, 0};
    vt[16] = '{5'd3,  32'd9, 32'd5, 32'd0, 32'd4, 1'b0, SL};

    #1 clear_n = 1'b0;
    #2;
    chk("rst_result_valid", {63'd0, result_valid}, 64'd0);
    chk("rst_strobes", {51'd0, stb}, 64'd0);
    chk("rst_a", {32'd0, A}, 64'd0);
    chk("rst_b", {32'd0, B}, 64'd0);
    chk("rst_z", {z_hi, z_lo}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    @(posedge clk);
    #1 clear_n = 1'b1;
    @(negedge clk);
    chk("rst_instr_ready", {63'd0, instr_ready}, 64'd1);

    for (int i = 0; i < 17; i++) begin
      issue(vt[i]);
      drain(vt[i].lat);
    end

    // SUB held in RESP while a new instruction is offered.
    @(posedge clk);
    #1 result_ready = 1'b0;
    issue('{5'd3, 32'd5, 32'd9, 32'd0, 32'hFFFF_FFFC, 1'b0, SL});
    @(posedge clk);
    #1;
    instr_valid = 1'b1;
    opcode = 5'd2;
    ra_data = 32'd3;
    rb_data = 32'd4;
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, result_valid}, 64'd1);
      chk("hold_ready", {63'd0, instr_ready}, 64'd0);
      chk("hold_z_lo", {32'd0, z_lo}, 64'hFFFF_FFFC);
    end
    @(posedge clk);
    #1 result_ready = 1'b1;
    @(negedge clk);
    chk("no_overlap", {63'd0, instr_ready}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("idle_ready", {63'd0, instr_ready}, 64'd1);
    chk("valid_drop", {63'd0, result_valid}, 64'd0);
    chk("idle_z_hold", {32'd0, z_lo}, 64'hFFFF_FFFC);
    @(posedge clk);
    #1;
    push('{5'd2, 32'd3, 32'd4, 32'd0, 32'd7, 1'b0, SL});
    instr_valid = 1'b0;
    drain(SL);

    // Reset in the tenth EXEC cycle of a DIV.
    issue('{5'd5, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DL});
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 clear_n = 1'b0;
    #1;
    chk("abort_strobes", {51'd0, stb}, 64'd0);
    chk("abort_a", {32'd0, A}, 64'd0);
    chk("abort_b", {32'd0, B}, 64'd0);
    chk("abort_valid", {63'd0, result_valid}, 64'd0);
    @(posedge clk);
    #1 clear_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid || stb != '0) bad++;
    end
    chk("abort_no_result", 64'(bad), 64'd0);
    chk("abort_ready", {63'd0, instr_ready}, 64'd1);
    v = '{5'd2, 32'd1, 32'd1, 32'd0, 32'd2, 1'b0, SL};
    issue(v);
    drain(SL);

    chk("idle_activity", 64'(idle_bad), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue-side controller for the Alu datapath block; it drives the Alu's one-hot op strobes and A/B operands, and captures its 64-bit C result.
- Accepts one decoded ALU instruction at a time (opcode plus two 32-bit operands) over a valid/ready handshake.
- Holds the strobe for a per-operation latency, latches C into Z_HI/Z_LO, and presents the result over a second valid/ready handshake.
- Sits between the instruction decode/register-read stage and the Alu.

Parameters:
- SIMPLE_LAT, 1, cycles from first strobe cycle until C is valid for all ops except MUL and DIV (range 1..63)
- MUL_LAT, 3, same, for MUL (range 1..63)
- DIV_LAT, 34, same, for DIV (range 1..63)

Ports:
- clk  in  1  system clock, rising edge
- clear_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept an instruction
- opcode  in  5  operation select (encoding below)
- ra_data  in  32  first operand
- rb_data  in  32  second operand
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC  out  1 each  one-hot Alu op strobes
- A  out  32  Alu operand A
- B  out  32  Alu operand B
- C  in  64  Alu result
- result_valid  out  1  Z_HI/Z_LO/err valid
- result_ready  in  1  consumer accepts the result
- z_hi  out  32  captured C[63:32]
- z_lo  out  32  captured C[31:0]
- err  out  1  the instruction had an illegal opcode

Behaviour:
- Opcode encoding: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 SHR, 7 SHL, 8 ROR, 9 ROL, 10 NEG, 11 NOT, 12 IncPC. Values 13..31 are illegal.
- Reset (clear_n low, asynchronous):
  - state IDLE
  - all strobes 0
  - A, B, z_hi, z_lo = 0
  - err = 0, result_valid = 0, latency counter = 0
  - instr_ready = 1 once clear_n is high
- Reset mid-operation aborts the operation; no result is produced.
- States: IDLE, EXEC, RESP.
- IDLE:
  - instr_ready = 1.
  - On an edge with instr_valid & instr_ready: A <= ra_data, B <= rb_data, opcode latched.
  - Legal opcode: counter <= op latency, go EXEC.
  - Illegal opcode: err <= 1, z_hi/z_lo <= 0, go RESP directly; no strobe is ever asserted.
- EXEC:
  - instr_ready = 0.
  - Exactly one strobe is high, selected by the latched opcode. All others are 0.
  - Strobe is held for the whole of EXEC. A and B are stable.
  - Counter decrements each cycle.
  - On the edge where the counter equals 1: z_hi <= C[63:32], z_lo <= C[31:0], err <= 0, strobe drops, go RESP.
  - The strobe is therefore high for exactly LAT cycles.
- RESP:
  - result_valid = 1, instr_ready = 0.
  - z_hi, z_lo and err are held stable until an edge with result_ready = 1, then go IDLE.
  - result_valid deasserts in the following cycle.
- Timing:
  - With accept on edge k, the strobe is high in cycles k+1 .. k+LAT.
  - result_valid is high from cycle k+LAT+1.
  - Minimum issue interval is LAT+2 cycles.
- No overlap: a new instruction is never accepted in RESP, even if result_ready is high in that cycle.
- Strobes are registered outputs, glitch-free, and never two-hot. A strobe is never high outside EXEC.
- Values outside IDLE:
  - instr_valid and operand changes outside IDLE are ignored.
  - Changes on C outside the capture edge are ignored.
- z_hi/z_lo keep their last values in IDLE. They are never cleared except by reset or an illegal opcode.

Test Plan:
- ADD, ra=22, rb=24, Alu model registered (SIMPLE_LAT=1) -> ADD high for exactly 1 cycle; z_lo=46, z_hi=0, err=0; result_valid 2 cycles after the accept edge.
- MUL, ra=22, rb=24, MUL_LAT=3 -> MUL high for 3 cycles, no other strobe ever high; z_lo=528, z_hi=0; instr_ready low for 4 cycles with result_ready tied high.
- DIV, ra=100, rb=7, DIV_LAT=34 -> DIV high for 34 cycles; z_lo=14 and z_hi=2 (quotient and remainder per the Alu model); result_valid on cycle 35.
- Opcode 20 -> zero strobe activity; err=1, z_hi=z_lo=0, result_valid next cycle. Then opcode 11 (NOT), ra=0 -> err=0, z_lo=32'hFFFFFFFF.
- SUB, ra=5, rb=9, with result_ready held low 3 cycles in RESP and instr_valid held high with new operands -> result_valid, z_lo=32'hFFFFFFFC and instr_ready all held; the new instruction is accepted only after the RESP->IDLE transition.
- clear_n pulsed low mid-DIV (cycle 10 of EXEC) -> strobes and A/B go to 0 immediately and result_valid never asserts. After release, instr_ready=1 and an ADD 1+1 yields z_lo=2.
